adder_tree_acc: RTL and testbench
=================================

Name: adder_tree_acc

Overview:
Parametrised successor to the two-operand registered adder. Sums NUM_IN operands per cycle through a fully pipelined, registered adder tree. Then either outputs the sum directly or accumulates it into a saturating accumulator. Used as the reduction/accumulate back-end for multi-lane datapaths; one new sample per cycle, valid-qualified.

Parameters:
BITWIDTH, 8, width of each input operand
NUM_IN, 4, operand count; power of 2, >= 2; LOG = log2(NUM_IN)
ACC_WIDTH, BITWIDTH+LOG+8, output/accumulator width; must be >= BITWIDTH+LOG
SIGNED, 0, 0 = unsigned operands/arithmetic, 1 = two's complement

Ports:
iClk  in  1  clock, all state on rising edge
iRst  in  1  reset, synchronous, active-high
iEn  in  1  input valid; sample on iData accepted when high
iClr  in  1  synchronous clear/flush
iMode  in  1  0 = sum mode, 1 = accumulate mode; captured with the sample
iData  in  NUM_IN*BITWIDTH  packed operands, lane i = iData[i*BITWIDTH +: BITWIDTH]
oData  out  ACC_WIDTH  result / accumulator value
oValid  out  1  one-cycle pulse, high in the cycle oData holds a newly produced result
oOvf  out  1  sticky saturation flag

Behaviour:
- Reset: on iRst high at a clock edge, oData=0, oValid=0, oOvf=0, all pipeline data and valid bits cleared. iRst has priority over everything.
- Tree: LOG registered levels; level k adds pairs and grows width by 1 bit.
  - Extension per SIGNED: sign-extend if SIGNED=1, zero-extend if 0.
  - Final tree sum is exactly BITWIDTH+LOG bits; no overflow possible inside the tree.
- Each stage carries a valid bit and the mode bit with its data. A mode change mid-stream applies per sample, never retroactively.
- Output stage, registered, when the stage valid is set:
  - Mode 0: oData = extend(sum) to ACC_WIDTH.
  - Mode 1: oData = sat(oData + extend(sum)).
- Saturation:
  - Unsigned: clamp at 2^ACC_WIDTH-1.
  - Signed: clamp at +2^(ACC_WIDTH-1)-1 / -2^(ACC_WIDTH-1).
  - Any clamp sets oOvf=1. oOvf stays set until iClr or iRst; mode 0 never sets or clears it.
- Latency: sample accepted at edge n gives oValid=1 and the result on oData after edge n+LOG+1 (3 cycles for NUM_IN=4).
  - Throughput 1 sample/cycle, no backpressure.
  - Back-to-back accumulates use the previous result correctly, with no bubble required.
- iEn low inserts a bubble: in that output cycle oValid=0 and oData holds its value.
- iClr high at an edge:
  - oData=0, oOvf=0, oValid=0.
  - All in-flight valid bits are cleared (flush); a sample presented with iEn in the same cycle is dropped.
  - iClr wins over iEn. Samples accepted after the clear cycle proceed normally.
- Accumulating mode-1 sample after a mode-0 result: adds to the mode-0 result held in oData.
- Data registers need not clear on bubbles; only valid bits gate updates.
- No combinational path from inputs to outputs.

Test Plan:
1. Reset/idle: iRst=1 for 2 cycles with iEn=1, iData nonzero -> oData=0, oValid=0, oOvf=0 throughout, and for 3 cycles after release without iEn.
2. Sum latency (default params):
   - Stimulus: iMode=0, iEn=1 one cycle, lanes {255,255,255,255}.
   - Required: oValid pulses exactly 3 cycles later with oData=1020; oData holds 1020 afterwards with oValid=0.
3. Accumulate back-to-back:
   - Stimulus: iClr pulse, then 3 consecutive mode-1 samples {1,2,3,4}.
   - Required: oValid on 3 consecutive cycles with oData=10, 20, 30; a bubble cycle between samples 2 and 3 gives 10, 20, hold, 30.
4. Saturation (ACC_WIDTH=10, unsigned):
   - Stimulus: two mode-1 samples of {255,255,255,255}.
   - Required: oData=1020 then 1023, oOvf=1 sticky.
   - Then a mode-0 sample {0,0,0,1} -> oData=1, oOvf still 1; iClr -> oOvf=0.
5. Signed (SIGNED=1):
   - Mode 0, lanes {-128,-128,-128,-128} -> oData=-512 sign-extended.
   - Mode 1 from clear with {127,-1,0,0} twice -> 126, 252.
   - With ACC_WIDTH=10, accumulate -512 twice -> -512, then -512 clamped, oOvf=1.
6. Flush:
   - Stimulus: iEn at cycle 0 and 1, iClr at cycle 1.
   - Required: no oValid from either sample, oData=0.
   - A sample at cycle 2 ({1,1,1,1}, mode 1) -> oValid at cycle 5 with oData=4.

Source files
------------

// File: rtl/adder_tree_acc.sv
// adder_tree_acc
//   Reduces NUM_IN packed operands per cycle through a fully registered
//   binary adder tree, then either passes the tree sum straight out (sum
//   mode) or adds it into a saturating accumulator (accumulate mode).
//   A sample carries its own valid and mode bits down the pipeline, so a
//   mode change mid-stream affects only the samples that request it.
//
// Parameters
//   BITWIDTH   width of one operand lane
//   NUM_IN     operand count, a power of two >= 2
//   ACC_WIDTH  result / accumulator width, >= BITWIDTH + log2(NUM_IN)
//   SIGNED     0 = unsigned arithmetic, 1 = two's complement
//
// Ports
//   iClk    clock, all state updates on the rising edge
//   iRst    synchronous active-high reset, highest priority
//   iEn     input valid, iData is accepted when high
//   iClr    synchronous clear: zeroes result and flag, flushes the pipeline
//   iMode   0 = sum mode, 1 = accumulate mode, travels with the sample
//   iData   packed operands, lane i = iData[i*BITWIDTH +: BITWIDTH]
//   oData   result or accumulator value
//   oValid  one-cycle pulse when oData holds a newly produced result
//   oOvf    sticky saturation flag, cleared only by iClr or iRst
//
// Latency is LOG tree levels plus the output register: a sample presented
// in cycle n appears on oData / oValid in cycle n + LOG + 1.

module adder_tree_acc #(
  parameter int BITWIDTH  = 8,
  parameter int NUM_IN    = 4,
  parameter int ACC_WIDTH = BITWIDTH + $clog2(NUM_IN) + 8,
  parameter int SIGNED    = 0
) (
  input  logic                         iClk,
  input  logic                         iRst,
  input  logic                         iEn,
  input  logic                         iClr,
  input  logic                         iMode,
  input  logic [NUM_IN*BITWIDTH-1:0]   iData,
  output logic [ACC_WIDTH-1:0]         oData,
  output logic                         oValid,
  output logic                         oOvf
);

  localparam int  LOG       = $clog2(NUM_IN);
  localparam int  SUMW      = BITWIDTH + LOG;
  localparam int  HALF      = NUM_IN / 2;
  localparam bit  IS_SIGNED = (SIGNED != 0);

  // Every tree node is kept at the final sum width. The operands are
  // extended once at the input, so each level's pairwise add is exact and
  // the top node can never overflow.
  logic [SUMW-1:0]      laneExt  [NUM_IN];
  logic [SUMW-1:0]      treeReg  [LOG][HALF];
  logic [LOG-1:0]       stageValid;
  logic [LOG-1:0]       stageMode;

  logic [SUMW-1:0]      sumTop;
  logic                 sumSign;
  logic [ACC_WIDTH:0]   sumWide;
  logic [ACC_WIDTH:0]   accWide;
  logic [ACC_WIDTH:0]   total;
  logic [ACC_WIDTH-1:0] accNext;
  logic                 accSat;

  localparam logic [ACC_WIDTH-1:0] UMAX = {ACC_WIDTH{1'b1}};
  localparam logic [ACC_WIDTH-1:0] SMAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic [ACC_WIDTH-1:0] SMIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

  // Extend each incoming lane to the tree width (sign or zero fill).
  always_comb begin
    for (int i = 0; i < NUM_IN; i++) begin
      logic [BITWIDTH-1:0] lane;
      lane       = iData[i*BITWIDTH +: BITWIDTH];
      laneExt[i] = {{LOG{IS_SIGNED & lane[BITWIDTH-1]}}, lane};
    end
  end

  // Adder tree. Level 0 adds input pairs, level k adds pairs of level k-1.
  // Data registers update every cycle; only the valid bits decide whether
  // the output stage uses them.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      for (int k = 0; k < LOG; k++) begin
        for (int j = 0; j < HALF; j++) begin
          treeReg[k][j] <= '0;
        end
      end
    end else begin
      for (int j = 0; j < HALF; j++) begin
        treeReg[0][j] <= laneExt[2*j] + laneExt[2*j+1];
      end
      for (int k = 1; k < LOG; k++) begin
        for (int j = 0; j < (NUM_IN >> (k + 1)); j++) begin
          treeReg[k][j] <= treeReg[k-1][2*j] + treeReg[k-1][2*j+1];
        end
      end
    end
  end

  // Valid and mode bits ride alongside the tree data. A clear flushes all
  // in-flight valids and also drops the sample presented in that cycle.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      stageValid <= '0;
      stageMode  <= '0;
    end else begin
      for (int k = LOG - 1; k > 0; k--) begin
        stageValid[k] <= stageValid[k-1] & ~iClr;
        stageMode[k]  <= stageMode[k-1];
      end
      stageValid[0] <= iEn & ~iClr;
      stageMode[0]  <= iMode;
    end
  end

  // Accumulate with one guard bit. For unsigned the carry out means the
  // true sum passed the maximum; for signed, a guard bit that disagrees
  // with the top bit means the true sum left the representable range and
  // the guard bit gives the direction.
  always_comb begin
    sumTop  = treeReg[LOG-1][0];
    sumSign = IS_SIGNED & sumTop[SUMW-1];
    sumWide = {{(ACC_WIDTH + 1 - SUMW){sumSign}}, sumTop};
    accWide = {IS_SIGNED & oData[ACC_WIDTH-1], oData};
    total   = accWide + sumWide;
    accNext = total[ACC_WIDTH-1:0];
    accSat  = 1'b0;
    if (IS_SIGNED) begin
      if (total[ACC_WIDTH] != total[ACC_WIDTH-1]) begin
        accSat  = 1'b1;
        accNext = total[ACC_WIDTH] ? SMIN : SMAX;
      end
    end else begin
      if (total[ACC_WIDTH]) begin
        accSat  = 1'b1;
        accNext = UMAX;
      end
    end
  end

  // Output register. A bubble leaves oData untouched and drops oValid.
  // Sum mode overwrites oData without touching the sticky flag, so a later
  // accumulate continues from that sum.
  always_ff @(posedge iClk) begin
    if (iRst || iClr) begin
      oData  <= '0;
      oValid <= 1'b0;
      oOvf   <= 1'b0;
    end else if (stageValid[LOG-1]) begin
      oValid <= 1'b1;
      if (!stageMode[LOG-1]) begin
        oData <= sumWide[ACC_WIDTH-1:0];
      end else begin
        oData <= accNext;
        if (accSat) begin
          oOvf <= 1'b1;
        end
      end
    end else begin
      oValid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_adder_tree_acc.sv
// tb_adder_tree_acc
//   Four instances share one stimulus stream:
//     u0 default (unsigned, 18-bit acc), u1 unsigned 10-bit acc,
//     u2 signed 18-bit acc,               u3 signed 10-bit acc.
//   Directed scenarios compare against hand-derived constants; the random
//   scenario compares every instance with an integer reference model.

module tb_adder_tree_acc;

  logic        iClk = 1'b0;
  logic        iRst = 1'b1;
  logic        iEn = 1'b0;
  logic        iClr = 1'b0;
  logic        iMode = 1'b0;
  logic [31:0] iData = '0;

  logic [17:0] oData0, oData2;
  logic [9:0]  oData1, oData3;
  logic        oValid0, oValid1, oValid2, oValid3;
  logic        oOvf0, oOvf1, oOvf2, oOvf3;

  int errors = 0;
  int checks = 0;

  always #5 iClk = ~iClk;

  adder_tree_acc u0 (.iClk(iClk), .iRst(iRst), .iEn(iEn), .iClr(iClr), .iMode(iMode),
                     .iData(iData), .oData(oData0), .oValid(oValid0), .oOvf(oOvf0));
  adder_tree_acc #(.ACC_WIDTH(10)) u1 (.iClk(iClk), .iRst(iRst), .iEn(iEn), .iClr(iClr),
                     .iMode(iMode), .iData(iData), .oData(oData1), .oValid(oValid1), .oOvf(oOvf1));
  adder_tree_acc #(.SIGNED(1)) u2 (.iClk(iClk), .iRst(iRst), .iEn(iEn), .iClr(iClr),
                     .iMode(iMode), .iData(iData), .oData(oData2), .oValid(oValid2), .oOvf(oOvf2));
  adder_tree_acc #(.ACC_WIDTH(10), .SIGNED(1)) u3 (.iClk(iClk), .iRst(iRst), .iEn(iEn),
                     .iClr(iClr), .iMode(iMode), .iData(iData), .oData(oData3), .oValid(oValid3),
                     .oOvf(oOvf3));

  // Reference model: per-sample behaviour with plain integer arithmetic.
  // A sample presented in cycle n produces its result after LOG+1 = 3 edges.
  typedef struct { bit v; bit m; logic [31:0] d; } samp_t;
  samp_t  inFlight [$];
  longint mAcc [4];
  bit     mVld [4];
  bit     mOvf [4];
  int     cfgW [4] = '{18, 10, 18, 10};
  bit     cfgS [4] = '{0, 0, 1, 1};

  function automatic longint laneSum(logic [31:0] d, bit sg);
    longint s = 0;
    for (int i = 0; i < 4; i++) begin
      logic [7:0] u;
      u = d[i*8 +: 8];
      s += longint'(u);
      if (sg && u[7]) s -= 256;
    end
    return s;
  endfunction

  always @(posedge iClk) begin
    if (iRst || iClr) begin
      inFlight.delete();
      for (int c = 0; c < 4; c++) begin
        mAcc[c] = 0; mVld[c] = 0; mOvf[c] = 0;
      end
    end else begin
      samp_t s;
      inFlight.push_back('{iEn, iMode, iData});
      s = '{0, 0, '0};
      if (inFlight.size() > 2) s = inFlight.pop_front();
      for (int c = 0; c < 4; c++) begin
        mVld[c] = s.v;
        if (s.v) begin
          longint sum, mx, mn, t;
          sum = laneSum(s.d, cfgS[c]);
          mx  = cfgS[c] ? (longint'(1) << (cfgW[c] - 1)) - 1 : (longint'(1) << cfgW[c]) - 1;
          mn  = cfgS[c] ? -(longint'(1) << (cfgW[c] - 1)) : 0;
          if (!s.m) mAcc[c] = sum;
          else begin
            t = mAcc[c] + sum;
            if (t > mx) begin mAcc[c] = mx; mOvf[c] = 1; end
            else if (t < mn) begin mAcc[c] = mn; mOvf[c] = 1; end
            else mAcc[c] = t;
          end
        end
      end
    end
  end

  task automatic drive(input bit en, input bit clr, input bit mode, input logic [31:0] d);
    iEn = en; iClr = clr; iMode = mode; iData = d;
  endtask

  task automatic cyc();
    @(posedge iClk);
    #1;
  endtask

  task automatic test_reset();
    iRst = 1'b1;
    drive(1, 0, 1, 32'hDEADBEEF);
    for (int t = 0; t < 2; t++) begin
      cyc();
      checks++;
      if ({oData0, oValid0, oOvf0} !== 20'd0) begin
        errors++; $display("[TB] FAIL reset_u0 t=%0d got=%h want=0", t, {oData0, oValid0, oOvf0});
      end
      checks++;
      if ({oData3, oValid3, oOvf3} !== 12'd0) begin
        errors++; $display("[TB] FAIL reset_u3 t=%0d got=%h want=0", t, {oData3, oValid3, oOvf3});
      end
    end
    iRst = 1'b0;
    drive(0, 0, 0, 32'hDEADBEEF);
    for (int t = 0; t < 3; t++) begin
      cyc();
      checks++;
      if ({oData0, oValid0, oOvf0} !== 20'd0) begin
        errors++; $display("[TB] FAIL idle_u0 t=%0d got=%h want=0", t, {oData0, oValid0, oOvf0});
      end
    end
  endtask

  task automatic test_sum_latency();
    logic [17:0] eD [5] = '{0, 0, 1020, 1020, 1020};
    bit          eV [5] = '{0, 0, 1, 0, 0};
    for (int t = 0; t < 5; t++) begin
      if (t == 0) drive(1, 0, 0, 32'hFFFFFFFF);
      else        drive(0, 0, 0, 32'h0);
      cyc();
      checks++;
      if ({oData0, oValid0} !== {eD[t], eV[t]}) begin
        errors++; $display("[TB] FAIL sum_u0 t=%0d got=%0d/%b want=%0d/%b", t, oData0, oValid0, eD[t], eV[t]);
      end
      checks++;
      if ({oData1, oValid1} !== {eD[t][9:0], eV[t]}) begin
        errors++; $display("[TB] FAIL sum_u1 t=%0d got=%0d/%b want=%0d/%b", t, oData1, oValid1, eD[t], eV[t]);
      end
    end
  endtask

  task automatic test_accumulate();
    bit          en1 [7] = '{0, 1, 1, 1, 0, 0, 0};
    logic [17:0] eD1 [7] = '{0, 0, 0, 10, 20, 30, 30};
    bit          eV1 [7] = '{0, 0, 0, 1, 1, 1, 0};
    bit          en2 [8] = '{0, 1, 1, 0, 1, 0, 0, 0};
    logic [17:0] eD2 [8] = '{0, 0, 0, 10, 20, 20, 30, 30};
    bit          eV2 [8] = '{0, 0, 0, 1, 1, 0, 1, 0};
    for (int t = 0; t < 7; t++) begin
      drive(en1[t], t == 0, 1, 32'h04030201);
      cyc();
      checks++;
      if ({oData0, oValid0} !== {eD1[t], eV1[t]}) begin
        errors++; $display("[TB] FAIL acc_u0 t=%0d got=%0d/%b want=%0d/%b", t, oData0, oValid0, eD1[t], eV1[t]);
      end
      checks++;
      if ({oData2, oValid2} !== {eD1[t], eV1[t]}) begin
        errors++; $display("[TB] FAIL acc_u2 t=%0d got=%0d/%b want=%0d/%b", t, oData2, oValid2, eD1[t], eV1[t]);
      end
    end
    for (int t = 0; t < 8; t++) begin
      drive(en2[t], t == 0, 1, 32'h04030201);
      cyc();
      checks++;
      if ({oData0, oValid0} !== {eD2[t], eV2[t]}) begin
        errors++; $display("[TB] FAIL acc_bubble_u0 t=%0d got=%0d/%b want=%0d/%b", t, oData0, oValid0, eD2[t], eV2[t]);
      end
    end
  endtask

  task automatic test_saturation();
    bit          en  [9] = '{0, 1, 1, 0, 0, 1, 0, 0, 0};
    bit          clr [9] = '{1, 0, 0, 0, 0, 0, 0, 0, 1};
    bit          md  [9] = '{0, 1, 1, 0, 0, 0, 0, 0, 0};
    logic [31:0] dat [9] = '{0, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0, 32'h00000001, 0, 0, 0};
    logic [9:0]  eD1 [9] = '{0, 0, 0, 1020, 1023, 1023, 1023, 1, 0};
    logic [17:0] eD0 [9] = '{0, 0, 0, 1020, 2040, 2040, 2040, 1, 0};
    bit          eV  [9] = '{0, 0, 0, 1, 1, 0, 0, 1, 0};
    bit          eO  [9] = '{0, 0, 0, 0, 1, 1, 1, 1, 0};
    for (int t = 0; t < 9; t++) begin
      drive(en[t], clr[t], md[t], dat[t]);
      cyc();
      checks++;
      if ({oData1, oValid1, oOvf1} !== {eD1[t], eV[t], eO[t]}) begin
        errors++; $display("[TB] FAIL sat_u1 t=%0d got=%0d/%b/%b want=%0d/%b/%b",
                           t, oData1, oValid1, oOvf1, eD1[t], eV[t], eO[t]);
      end
      checks++;
      if ({oData0, oValid0, oOvf0} !== {eD0[t], eV[t], 1'b0}) begin
        errors++; $display("[TB] FAIL sat_u0 t=%0d got=%0d/%b/%b want=%0d/%b/0",
                           t, oData0, oValid0, oOvf0, eD0[t], eV[t]);
      end
    end
  endtask

  task automatic test_signed();
    bit          en  [15] = '{0, 1, 0, 0, 0, 1, 1, 0, 0, 0, 1, 1, 0, 0, 0};
    bit          clr [15] = '{1, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0};
    bit          md  [15] = '{0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 1, 1, 0, 0, 0};
    logic [31:0] dat [15] = '{0, 32'h80808080, 0, 0, 0, 32'h0000FF7F, 32'h0000FF7F, 0, 0, 0,
                              32'h80808080, 32'h80808080, 0, 0, 0};
    logic [17:0] eD2 [15] = '{0, 0, 0, 18'h3FE00, 0, 0, 0, 126, 252, 0, 0, 0,
                              18'h3FE00, 18'h3FC00, 18'h3FC00};
    logic [9:0]  eD3 [15] = '{0, 0, 0, 10'h200, 0, 0, 0, 126, 252, 0, 0, 0,
                              10'h200, 10'h200, 10'h200};
    bit          eV  [15] = '{0, 0, 0, 1, 0, 0, 0, 1, 1, 0, 0, 0, 1, 1, 0};
    bit          eO3 [15] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1};
    for (int t = 0; t < 15; t++) begin
      drive(en[t], clr[t], md[t], dat[t]);
      cyc();
      checks++;
      if ({oData2, oValid2, oOvf2} !== {eD2[t], eV[t], 1'b0}) begin
        errors++; $display("[TB] FAIL signed_u2 t=%0d got=%h/%b/%b want=%h/%b/0",
                           t, oData2, oValid2, oOvf2, eD2[t], eV[t]);
      end
      checks++;
      if ({oData3, oValid3, oOvf3} !== {eD3[t], eV[t], eO3[t]}) begin
        errors++; $display("[TB] FAIL signed_u3 t=%0d got=%h/%b/%b want=%h/%b/%b",
                           t, oData3, oValid3, oOvf3, eD3[t], eV[t], eO3[t]);
      end
    end
  endtask

  task automatic test_flush();
    bit          en  [7] = '{0, 1, 1, 1, 0, 0, 0};
    bit          clr [7] = '{1, 0, 1, 0, 0, 0, 0};
    logic [31:0] dat [7] = '{0, 32'h55555555, 32'h66666666, 32'h01010101, 0, 0, 0};
    logic [17:0] eD  [7] = '{0, 0, 0, 0, 0, 4, 4};
    bit          eV  [7] = '{0, 0, 0, 0, 0, 1, 0};
    for (int t = 0; t < 7; t++) begin
      drive(en[t], clr[t], 1, dat[t]);
      cyc();
      checks++;
      if ({oData0, oValid0} !== {eD[t], eV[t]}) begin
        errors++; $display("[TB] FAIL flush_u0 t=%0d got=%0d/%b want=%0d/%b", t, oData0, oValid0, eD[t], eV[t]);
      end
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 500; n++) begin
      logic [31:0] d;
      for (int i = 0; i < 4; i++) begin
        case ($urandom_range(0, 4))
          0:       d[i*8 +: 8] = 8'hFF;
          1:       d[i*8 +: 8] = 8'h80;
          2:       d[i*8 +: 8] = 8'h7F;
          default: d[i*8 +: 8] = 8'($urandom);
        endcase
      end
      iRst = ($urandom_range(0, 99) == 0);
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 24) == 0, 1'($urandom), d);
      cyc();
      checks++;
      if ({oData0, oValid0, oOvf0} !== {mAcc[0][17:0], mVld[0], mOvf[0]}) begin
        errors++; $display("[TB] FAIL rand_u0 n=%0d got=%h/%b/%b want=%h/%b/%b",
                           n, oData0, oValid0, oOvf0, mAcc[0][17:0], mVld[0], mOvf[0]);
      end
      checks++;
      if ({oData1, oValid1, oOvf1} !== {mAcc[1][9:0], mVld[1], mOvf[1]}) begin
        errors++; $display("[TB] FAIL rand_u1 n=%0d got=%h/%b/%b want=%h/%b/%b",
                           n, oData1, oValid1, oOvf1, mAcc[1][9:0], mVld[1], mOvf[1]);
      end
      checks++;
      if ({oData2, oValid2, oOvf2} !== {mAcc[2][17:0], mVld[2], mOvf[2]}) begin
        errors++; $display("[TB] FAIL rand_u2 n=%0d got=%h/%b/%b want=%h/%b/%b",
                           n, oData2, oValid2, oOvf2, mAcc[2][17:0], mVld[2], mOvf[2]);
      end
      checks++;
      if ({oData3, oValid3, oOvf3} !== {mAcc[3][9:0], mVld[3], mOvf[3]}) begin
        errors++; $display("[TB] FAIL rand_u3 n=%0d got=%h/%b/%b want=%h/%b/%b",
                           n, oData3, oValid3, oOvf3, mAcc[3][9:0], mVld[3], mOvf[3]);
      end
    end
    iRst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_sum_latency();
    test_accumulate();
    test_saturation();
    test_signed();
    test_flush();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
